// File: rtl/checksum.sv
// XOR-key check byte comparator with registered, strobe-qualified frame logging,
// saturating good/bad counters and a sticky error flag.
module checksum #(
  parameter logic [7:0] KEY   = 8'h37,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic [7:0]       crc,
  output logic             result,
  output logic [7:0]       crc_gen,
  input  logic             in_valid,
  input  logic             clr,
  output logic             out_valid,
  output logic             out_match,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  logic [CNT_W-1:0] ok_base;
  logic [CNT_W-1:0] err_base;
  logic             sticky_base;
  logic [CNT_W-1:0] ok_next;
  logic [CNT_W-1:0] err_next;
  logic             sticky_next;

  assign crc_gen = data ^ KEY;
  assign result  = (crc == crc_gen);

  // Clear is applied before the beat is logged, so a beat coinciding with clr still counts.
  always_comb begin
    ok_base     = clr ? '0 : ok_cnt;
    err_base    = clr ? '0 : err_cnt;
    sticky_base = clr ? 1'b0 : err_sticky;
    ok_next     = ok_base;
    err_next    = err_base;
    sticky_next = sticky_base;
    if (in_valid) begin
      if (result) begin
        if (ok_base != '1) ok_next = ok_base + 1'b1;
      end else begin
        if (err_base != '1) err_next = err_base + 1'b1;
        sticky_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_match  <= 1'b0;
      out_data   <= '0;
      ok_cnt     <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_match <= result;
        out_data  <= data;
      end
      ok_cnt     <= ok_next;
      err_cnt    <= err_next;
      err_sticky <= sticky_next;
    end
  end

endmodule

// File: tb/tb_checksum.sv
// Directed self-checking bench for checksum with KEY=8'h37, CNT_W=16.
module tb_checksum;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic [7:0]  crc;
  logic        result;
  logic [7:0]  crc_gen;
  logic        in_valid;
  logic        clr;
  logic        out_valid;
  logic        out_match;
  logic [7:0]  out_data;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic        err_sticky;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  checksum #(.KEY(8'h37), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data(data), .crc(crc), .result(result), .crc_gen(crc_gen),
    .in_valid(in_valid), .clr(clr), .out_valid(out_valid), .out_match(out_match),
    .out_data(out_data), .ok_cnt(ok_cnt), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] cd [6]  = '{8'hAA, 8'hAD, 8'hAF, 8'hAA, 8'hAD, 8'hAF};
  logic [7:0] cc [6]  = '{8'h9D, 8'h9A, 8'h98, 8'h9C, 8'h98, 8'hAF};
  logic [7:0] cg [6]  = '{8'h9D, 8'h9A, 8'h98, 8'h9D, 8'h9A, 8'h98};
  logic       cr [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic [7:0] bd [3]  = '{8'hAA, 8'hAA, 8'hAF};
  logic [7:0] bc [3]  = '{8'h9D, 8'h9C, 8'h98};
  logic       bm [3]  = '{1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b1; data = 8'hAD; crc = 8'h9A;
    // Reset dominates in_valid; combinational compare stays live.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_result", result, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
    end
    check("rst_ok_cnt", ok_cnt, 16'h0);
    check("rst_err_cnt", err_cnt, 16'h0);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_match", out_match, 1'b0);

    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data = cd[i]; crc = cc[i];
      #1;
      check("comb_result", result, cr[i]);
      check("comb_crc_gen", crc_gen, cg[i]);
    end

    rst = 1'b0;
    tick();
    check("idle_out_valid", out_valid, 1'b0);

    for (int i = 0; i < 3; i++) begin
      data = bd[i]; crc = bc[i]; in_valid = 1'b1;
      tick();
      check("beat_out_valid", out_valid, 1'b1);
      check("beat_out_match", out_match, bm[i]);
      check("beat_out_data", out_data, bd[i]);
    end
    in_valid = 1'b0; data = 8'h11; crc = 8'h22;
    tick();
    check("hold_out_valid", out_valid, 1'b0);
    check("hold_out_match", out_match, 1'b1);
    check("hold_out_data", out_data, 8'hAF);
    check("seq_ok_cnt", ok_cnt, 16'd2);
    check("seq_err_cnt", err_cnt, 16'd1);
    check("seq_sticky", err_sticky, 1'b1);

    data = 8'hAA; crc = 8'h9C; in_valid = 1'b1; clr = 1'b1;
    tick();
    check("clrbeat_err_cnt", err_cnt, 16'd1);
    check("clrbeat_ok_cnt", ok_cnt, 16'd0);
    check("clrbeat_sticky", err_sticky, 1'b1);
    check("clrbeat_out_match", out_match, 1'b0);
    in_valid = 1'b0;
    tick();
    check("clr_err_cnt", err_cnt, 16'd0);
    check("clr_ok_cnt", ok_cnt, 16'd0);
    check("clr_sticky", err_sticky, 1'b0);
    check("clr_out_data", out_data, 8'hAA);
    clr = 1'b0;

    data = 8'hAD; crc = 8'h9A; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    check("sat_reach_ok_cnt", ok_cnt, 16'hFFFF);
    tick();
    check("sat_hold_ok_cnt", ok_cnt, 16'hFFFF);
    check("sat_err_cnt", err_cnt, 16'h0);
    check("sat_sticky", err_sticky, 1'b0);

    rst = 1'b1;
    tick();
    check("rerst_ok_cnt", ok_cnt, 16'h0);
    check("rerst_out_valid", out_valid, 1'b0);
    check("rerst_result", result, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
